// File: rtl/pid_servo_ctrl_if.sv
// Signal bundle between the loop supervisor (master) and the PID servo core (slave).
// Signal names are given from the core's point of view: i_ = into the core, o_ = out of it.
interface pid_servo_ctrl_if #(
  parameter int EW = 18,
  parameter int CW = 12,
  parameter int IW = 24,
  parameter int OW = 16
);
  logic                 i_enable;
  logic                 i_sample;
  logic        [EW-1:0] i_pos;
  logic        [EW-1:0] i_enc;
  logic        [CW-1:0] i_pc;
  logic        [CW-1:0] i_ic;
  logic        [CW-1:0] i_dc;
  logic        [IW-2:0] i_ilim;
  logic signed [OW-1:0] o_out;
  logic                 o_out_valid;
  logic                 o_busy;
  logic                 o_sat;
  logic signed [EW-1:0] o_pe;

  modport master (
    output i_enable, i_sample, i_pos, i_enc, i_pc, i_ic, i_dc, i_ilim,
    input  o_out, o_out_valid, o_busy, o_sat, o_pe
  );

  modport slave (
    input  i_enable, i_sample, i_pos, i_enc, i_pc, i_ic, i_dc, i_ilim,
    output o_out, o_out_valid, o_busy, o_sat, o_pe
  );
endinterface

// File: rtl/pid_servo_ctrl.sv
// Sequential PID position servo: one shared multiplier stepped by a small FSM.
// Define PID_DERIV_EN to build the derivative path (MUL_D state, latency 6); otherwise latency is 5.
module pid_servo_ctrl #(
  parameter int EW   = 18,
  parameter int CW   = 12,
  parameter int IW   = 24,
  parameter int OW   = 16,
  parameter int FRAC = 8
) (
  input logic             i_clk,
  input logic             i_rst_n,
  pid_servo_ctrl_if.slave bus
);
  localparam int AW = (IW > EW + 1) ? IW : EW + 1;
  localparam int PW = AW + CW + 1;
  localparam int SW = PW + 2;

  localparam logic signed [EW:0]   PE_MAX  = {2'b00, {(EW-1){1'b1}}};
  localparam logic signed [EW:0]   PE_MIN  = {2'b11, {(EW-1){1'b0}}};
  localparam logic signed [SW-1:0] OUT_MAX = {{(SW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [SW-1:0] OUT_MIN = {{(SW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    ERR,
    MUL_P,
    MUL_I,
`ifdef PID_DERIV_EN
    MUL_D,
`endif
    SUM,
    SAT
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic signed [EW-1:0] r_pe;
  logic signed [IW-1:0] r_ie;
  logic signed [PW-1:0] r_pt;
  logic signed [PW-1:0] r_it;
  logic signed [SW-1:0] r_sum;
  logic signed [OW-1:0] r_out;
  logic                 r_sat;
  logic                 r_out_valid;

  logic signed [EW:0]   w_diff;
  logic signed [EW-1:0] w_pe;
  logic signed [IW:0]   w_ie_sum;
  logic signed [IW:0]   w_lim;
  logic signed [IW:0]   w_nlim;
  logic signed [IW-1:0] w_ie_next;
  logic signed [PW-1:0] w_mul_a;
  logic signed [PW-1:0] w_mul_c;
  logic signed [PW-1:0] w_prod;
  logic signed [PW-1:0] w_term;
  logic signed [PW-1:0] w_dt;
  logic signed [SW-1:0] w_sum_next;
  logic signed [OW-1:0] w_out_sat;
  logic                 w_clip;

`ifdef PID_DERIV_EN
  logic signed [EW-1:0] r_pe_prev;
  logic signed [EW:0]   r_de;
  logic signed [PW-1:0] r_dt;
  logic signed [EW:0]   w_de;

  assign w_de = $signed({w_pe[EW-1], w_pe}) - $signed({r_pe_prev[EW-1], r_pe_prev});
  assign w_dt = r_dt;
`else
  logic w_unused_dc;

  assign w_unused_dc = ^bus.i_dc;
  assign w_dt        = '0;
`endif

  // Position error is formed one bit wider so Pos-Enc never wraps before clamping.
  assign w_diff = $signed({1'b0, bus.i_pos}) - $signed({1'b0, bus.i_enc});

  always_comb begin
    w_pe = w_diff[EW-1:0];
    if (w_diff > PE_MAX) begin
      w_pe = PE_MAX[EW-1:0];
    end else if (w_diff < PE_MIN) begin
      w_pe = PE_MIN[EW-1:0];
    end
  end

  assign w_ie_sum = $signed({r_ie[IW-1], r_ie}) + $signed({{(IW+1-EW){w_pe[EW-1]}}, w_pe});
  assign w_lim    = $signed({2'b00, bus.i_ilim});
  assign w_nlim   = -w_lim;

  always_comb begin
    w_ie_next = w_ie_sum[IW-1:0];
    if (w_ie_sum > w_lim) begin
      w_ie_next = w_lim[IW-1:0];
    end else if (w_ie_sum < w_nlim) begin
      w_ie_next = w_nlim[IW-1:0];
    end
  end

  // Shared multiplier: error operand and unsigned coefficient chosen by the current state.
  always_comb begin
    w_mul_a = '0;
    w_mul_c = '0;
    case (r_state)
      MUL_P: begin
        w_mul_a = {{(PW-EW){r_pe[EW-1]}}, r_pe};
        w_mul_c = {{(PW-CW){1'b0}}, bus.i_pc};
      end
      MUL_I: begin
        w_mul_a = {{(PW-IW){r_ie[IW-1]}}, r_ie};
        w_mul_c = {{(PW-CW){1'b0}}, bus.i_ic};
      end
`ifdef PID_DERIV_EN
      MUL_D: begin
        w_mul_a = {{(PW-EW-1){r_de[EW]}}, r_de};
        w_mul_c = {{(PW-CW){1'b0}}, bus.i_dc};
      end
`endif
      default: begin
        w_mul_a = '0;
        w_mul_c = '0;
      end
    endcase
  end

  assign w_prod     = w_mul_a * w_mul_c;
  assign w_term     = w_prod >>> FRAC;
  assign w_sum_next = $signed({{2{r_pt[PW-1]}}, r_pt}) + $signed({{2{r_it[PW-1]}}, r_it})
                    + $signed({{2{w_dt[PW-1]}}, w_dt});

  always_comb begin
    w_out_sat = r_sum[OW-1:0];
    w_clip    = 1'b0;
    if (r_sum > OUT_MAX) begin
      w_out_sat = OUT_MAX[OW-1:0];
      w_clip    = 1'b1;
    end else if (r_sum < OUT_MIN) begin
      w_out_sat = OUT_MIN[OW-1:0];
      w_clip    = 1'b1;
    end
  end

  // Enable low overrides everything, including a Sample in the same cycle.
  always_comb begin
    w_next = r_state;
    if (!bus.i_enable) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (bus.i_sample) w_next = ERR;
        ERR:     w_next = MUL_P;
        MUL_P:   w_next = MUL_I;
`ifdef PID_DERIV_EN
        MUL_I:   w_next = MUL_D;
        MUL_D:   w_next = SUM;
`else
        MUL_I:   w_next = SUM;
`endif
        SUM:     w_next = SAT;
        SAT:     w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_pe        <= '0;
      r_ie        <= '0;
      r_pt        <= '0;
      r_it        <= '0;
      r_sum       <= '0;
      r_out       <= '0;
      r_sat       <= 1'b0;
      r_out_valid <= 1'b0;
`ifdef PID_DERIV_EN
      r_pe_prev   <= '0;
      r_de        <= '0;
      r_dt        <= '0;
`endif
    end else begin
      r_state     <= w_next;
      r_out_valid <= 1'b0;
      if (!bus.i_enable) begin
        r_out <= '0;
        r_sat <= 1'b0;
        r_ie  <= '0;
`ifdef PID_DERIV_EN
        r_pe_prev <= r_pe;
`endif
      end else begin
        case (r_state)
          ERR: begin
            r_pe <= w_pe;
            r_ie <= w_ie_next;
`ifdef PID_DERIV_EN
            r_de      <= w_de;
            r_pe_prev <= w_pe;
`endif
          end
          MUL_P: r_pt <= w_term;
          MUL_I: r_it <= w_term;
`ifdef PID_DERIV_EN
          MUL_D: r_dt <= w_term;
`endif
          SUM:   r_sum <= w_sum_next;
          SAT: begin
            r_out       <= w_out_sat;
            r_sat       <= w_clip;
            r_out_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.o_out       = r_out;
  assign bus.o_out_valid = r_out_valid;
  assign bus.o_busy      = (r_state != IDLE);
  assign bus.o_sat       = r_sat;
  assign bus.o_pe        = r_pe;
endmodule

// File: tb/tb_pid_servo_ctrl.sv
// Directed-vector bench for pid_servo_ctrl; expectations are queued when a Sample is issued
// and a monitor pops them whenever Out_Valid pulses.
module tb_pid_servo_ctrl;
  localparam int EW   = 18;
  localparam int CW   = 12;
  localparam int IW   = 24;
  localparam int OW   = 16;
  localparam int FRAC = 8;
`ifdef PID_DERIV_EN
  localparam int LAT   = 6;
  localparam bit DERIV = 1'b1;
`else
  localparam int LAT   = 5;
  localparam bit DERIV = 1'b0;
`endif

  typedef struct {
    logic signed [OW-1:0] out;
    logic                 sat;
    logic signed [EW-1:0] pe;
    int                   cyc;
  } expItem_t;

  logic     clk = 1'b0;
  logic     rstN;
  int       cycleCnt = 0;
  int       nChecks  = 0;
  int       nFails   = 0;
  expItem_t scoreboard[$];
  expItem_t gotExp;

  pid_servo_ctrl_if #(.EW(EW), .CW(CW), .IW(IW), .OW(OW)) servoBus ();

  pid_servo_ctrl #(.EW(EW), .CW(CW), .IW(IW), .OW(OW), .FRAC(FRAC)) uDut (
    .i_clk   (clk),
    .i_rst_n (rstN),
    .bus     (servoBus)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic signed [31:0] act,
                             input logic signed [31:0] req);
    nChecks++;
    if (act !== req) begin
      nFails++;
      $display("[TB] FAIL %s: actual %0d, required %0d", name, act, req);
    end
  endtask

  // Drives one Sample strobe at the current negedge and queues its expected result.
  task automatic applyStimulus(input logic [EW-1:0] pos, input logic [EW-1:0] enc,
                               input logic [CW-1:0] pc, input logic [CW-1:0] ic,
                               input logic [CW-1:0] dc, input logic [IW-2:0] ilim,
                               input bit push, input logic signed [OW-1:0] expOut,
                               input logic expSat, input logic signed [EW-1:0] expPe);
    expItem_t item;
    servoBus.i_pos    = pos;
    servoBus.i_enc    = enc;
    servoBus.i_pc     = pc;
    servoBus.i_ic     = ic;
    servoBus.i_dc     = dc;
    servoBus.i_ilim   = ilim;
    servoBus.i_sample = 1'b1;
    if (push) begin
      item.out = expOut;
      item.sat = expSat;
      item.pe  = expPe;
      item.cyc = cycleCnt + 1 + LAT;
      scoreboard.push_back(item);
    end
    @(negedge clk);
    servoBus.i_sample = 1'b0;
  endtask

  task automatic waitDone();
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (servoBus.o_out_valid === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL wait_out_valid: actual no pulse within 20 cycles, required one pulse");
    end
  endtask

  // Monitor: every Out_Valid pulse must match the oldest queued expectation.
  initial forever begin
    @(posedge clk);
    #1;
    if (servoBus.o_out_valid === 1'b1) begin
      if (scoreboard.size() == 0) begin
        nChecks++;
        nFails++;
        $display("[TB] FAIL unexpected_valid: actual pulse at cycle %0d, required none", cycleCnt);
      end else begin
        gotExp = scoreboard.pop_front();
        checkOutput("out", servoBus.o_out, gotExp.out);
        checkOutput("sat", servoBus.o_sat, gotExp.sat);
        checkOutput("pe", servoBus.o_pe, gotExp.pe);
        checkOutput("latency_cycle", cycleCnt, gotExp.cyc);
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: actual simulation still running, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstN              = 1'b0;
    servoBus.i_enable = 1'b1;
    servoBus.i_sample = 1'b0;
    servoBus.i_pos    = '0;
    servoBus.i_enc    = '0;
    servoBus.i_pc     = '0;
    servoBus.i_ic     = '0;
    servoBus.i_dc     = '0;
    servoBus.i_ilim   = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_out", servoBus.o_out, 0);
    checkOutput("reset_valid", servoBus.o_out_valid, 0);
    checkOutput("reset_busy", servoBus.o_busy, 0);
    checkOutput("reset_sat", servoBus.o_sat, 0);
    checkOutput("reset_pe", servoBus.o_pe, 0);
    rstN = 1'b1;
    @(negedge clk);

    $display("[TB] proportional gain 2.0");
    applyStimulus(18'h090BE, 18'h090AE, 12'h200, 12'h000, 12'h000, 23'd1000, 1'b1, 16'sd32, 1'b0, 18'sd16);
    checkOutput("busy_after_sample", servoBus.o_busy, 1);
    waitDone();

    $display("[TB] integrator accumulation and limit");
    servoBus.i_enable = 1'b0;
    @(negedge clk);
    checkOutput("disable_busy", servoBus.o_busy, 0);
    checkOutput("disable_out", servoBus.o_out, 0);
    servoBus.i_enable = 1'b1;
    applyStimulus(18'h090BE, 18'h090AE, 12'h000, 12'h100, 12'h000, 23'd40, 1'b1, 16'sd16, 1'b0, 18'sd16);
    waitDone();
    applyStimulus(18'h090BE, 18'h090AE, 12'h000, 12'h100, 12'h000, 23'd40, 1'b1, 16'sd32, 1'b0, 18'sd16);
    waitDone();
    applyStimulus(18'h090BE, 18'h090AE, 12'h000, 12'h100, 12'h000, 23'd40, 1'b1, 16'sd40, 1'b0, 18'sd16);
    waitDone();
    applyStimulus(18'h090BE, 18'h090AE, 12'h000, 12'h100, 12'h000, 23'd40, 1'b1, 16'sd40, 1'b0, 18'sd16);
    waitDone();
    applyStimulus(18'h090BE, 18'h090AE, 12'h000, 12'h100, 12'h000, 23'd0, 1'b1, 16'sd0, 1'b0, 18'sd16);
    waitDone();
    applyStimulus(18'h00010, 18'h00020, 12'h000, 12'h100, 12'h000, 23'd20, 1'b1, -16'sd16, 1'b0, -18'sd16);
    waitDone();
    applyStimulus(18'h00010, 18'h00020, 12'h000, 12'h100, 12'h000, 23'd20, 1'b1, -16'sd20, 1'b0, -18'sd16);
    waitDone();

    $display("[TB] floor rounding of fractional gain");
    applyStimulus(18'h00000, 18'h00003, 12'h180, 12'h000, 12'h000, 23'd0, 1'b1, -16'sd5, 1'b0, -18'sd3);
    waitDone();
    applyStimulus(18'h00003, 18'h00000, 12'h180, 12'h000, 12'h000, 23'd0, 1'b1, 16'sd4, 1'b0, 18'sd3);
    waitDone();

    $display("[TB] error and output saturation");
    applyStimulus(18'h3FFFF, 18'h00000, 12'hFFF, 12'h000, 12'h000, 23'd0, 1'b1, 16'sh7FFF, 1'b1, 18'sh1FFFF);
    waitDone();
    applyStimulus(18'h00000, 18'h3FFFF, 12'hFFF, 12'h000, 12'h000, 23'd0, 1'b1, 16'sh8000, 1'b1, 18'sh20000);
    waitDone();
    applyStimulus(18'h07FFF, 18'h00000, 12'h100, 12'h000, 12'h000, 23'd0, 1'b1, 16'sh7FFF, 1'b0, 18'sd32767);
    waitDone();
    applyStimulus(18'h00000, 18'h08000, 12'h100, 12'h000, 12'h000, 23'd0, 1'b1, 16'sh8000, 1'b0, -18'sd32768);
    waitDone();
    applyStimulus(18'h08000, 18'h00000, 12'h100, 12'h000, 12'h000, 23'd0, 1'b1, 16'sh7FFF, 1'b1, 18'sd32768);
    waitDone();

    $display("[TB] derivative path");
    applyStimulus(18'h00100, 18'h00100, 12'h000, 12'h000, 12'h100, 23'd0, 1'b1,
                  DERIV ? 16'sh8000 : 16'sd0, 1'b0, 18'sd0);
    waitDone();
    applyStimulus(18'h00100, 18'h00100, 12'h000, 12'h000, 12'h100, 23'd0, 1'b1, 16'sd0, 1'b0, 18'sd0);
    waitDone();
    applyStimulus(18'h0010A, 18'h00100, 12'h000, 12'h000, 12'h100, 23'd0, 1'b1,
                  DERIV ? 16'sd10 : 16'sd0, 1'b0, 18'sd10);
    waitDone();
    applyStimulus(18'h0010A, 18'h00100, 12'h000, 12'h000, 12'h100, 23'd0, 1'b1, 16'sd0, 1'b0, 18'sd10);
    waitDone();

    $display("[TB] Sample while busy, then reset mid-computation");
    applyStimulus(18'h090BE, 18'h090AE, 12'h200, 12'h000, 12'h000, 23'd0, 1'b1, 16'sd32, 1'b0, 18'sd16);
    repeat (2) @(negedge clk);
    checkOutput("busy_third_cycle", servoBus.o_busy, 1);
    servoBus.i_sample = 1'b1;
    @(negedge clk);
    servoBus.i_sample = 1'b0;
    waitDone();
    repeat (LAT + 3) @(negedge clk);
    checkOutput("ignored_sample_busy", servoBus.o_busy, 0);
    applyStimulus(18'h090BE, 18'h090AE, 12'h300, 12'h000, 12'h000, 23'd0, 1'b0, 16'sd0, 1'b0, 18'sd0);
    repeat (3) @(negedge clk);
    rstN              = 1'b0;
    servoBus.i_sample = 1'b1;
    @(negedge clk);
    rstN              = 1'b1;
    servoBus.i_sample = 1'b0;
    checkOutput("midreset_busy", servoBus.o_busy, 0);
    checkOutput("midreset_out", servoBus.o_out, 0);
    checkOutput("midreset_sat", servoBus.o_sat, 0);
    checkOutput("midreset_pe", servoBus.o_pe, 0);
    checkOutput("midreset_valid", servoBus.o_out_valid, 0);
    repeat (LAT + 3) @(negedge clk);
    checkOutput("reset_sample_ignored", servoBus.o_busy, 0);

    $display("[TB] enable drop mid-computation");
    applyStimulus(18'h00105, 18'h00100, 12'h100, 12'h100, 12'h000, 23'd1000, 1'b1, 16'sd10, 1'b0, 18'sd5);
    waitDone();
    applyStimulus(18'h00105, 18'h00100, 12'h100, 12'h100, 12'h000, 23'd1000, 1'b0, 16'sd0, 1'b0, 18'sd0);
    @(negedge clk);
    servoBus.i_enable = 1'b0;
    @(negedge clk);
    checkOutput("enable_drop_busy", servoBus.o_busy, 0);
    checkOutput("enable_drop_out", servoBus.o_out, 0);
    checkOutput("enable_drop_sat", servoBus.o_sat, 0);
    servoBus.i_sample = 1'b1;
    @(negedge clk);
    checkOutput("enable_beats_sample", servoBus.o_busy, 0);
    servoBus.i_sample = 1'b0;
    servoBus.i_enable = 1'b1;
    @(negedge clk);
    checkOutput("sample_not_queued", servoBus.o_busy, 0);
    applyStimulus(18'h00105, 18'h00100, 12'h100, 12'h100, 12'h000, 23'd1000, 1'b1, 16'sd10, 1'b0, 18'sd5);
    waitDone();

    repeat (LAT + 3) @(negedge clk);
    checkOutput("scoreboard_empty", scoreboard.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule

// File: doc/pid_servo_ctrl.md
PID_SERVO_CTRL -- requirements
Module: pid_servo_ctrl

Interface
REQ-001 Parameter EW, default 18: encoder/position width, unsigned.
REQ-002 Parameter CW, default 12: coefficient width, unsigned.
REQ-003 Parameter IW, default 24: integrator width, signed.
REQ-004 Parameter OW, default 16: drive output width, signed.
REQ-005 Parameter FRAC, default 8: fractional bits of each coefficient, so 0x100 means gain 1.0.
REQ-006 Clock  in  1  single clock; all logic rising-edge.
REQ-007 Reset_n  in  1  reset; synchronous, active-low.
REQ-008 Enable  in  1  loop enable.
REQ-009 Sample  in  1  one-cycle start-of-computation strobe.
REQ-010 Pos  in  EW  commanded position.
REQ-011 Enc  in  EW  encoder count.
REQ-012 PC, IC, DC  in  CW each  proportional, integral and derivative coefficients.
REQ-013 ILIM  in  IW-1  integrator magnitude limit, unsigned.
REQ-014 Out  out  OW  signed motor drive value.
REQ-015 Out_Valid  out  1  one-cycle pulse when Out updates.
REQ-016 Busy  out  1  high while the computation FSM is not IDLE.
REQ-017 Sat  out  1  last Out was clamped.
REQ-018 PE  out  EW  signed position error, for display.

Function
REQ-019 Error: PE = Pos - Enc, computed at EW+1 bits and clamped to the signed EW range.
REQ-020 FSM states: IDLE, ERR, MUL_P, MUL_I, MUL_D, SUM, SAT; the sequence is fixed, one state per clock, with a single shared multiplier.
REQ-021 IDLE -> ERR when Sample=1 and Enable=1; Sample while Busy=1 is ignored and not queued.
REQ-022 ERR registers PE; IE = IE + PE, clamped to [-ILIM, +ILIM]; DE = PE - PE_prev; then PE_prev = PE.
REQ-023 Each term is (error x coefficient) arithmetic-right-shifted by FRAC (floor), at full product width: PT from PE*PC, IT from IE*IC, DT from DE*DC.
REQ-024 SUM adds PT+IT+DT at a width that cannot overflow; SAT clamps the sum to [-2^(OW-1), 2^(OW-1)-1] and sets Sat when clamping occurs.
REQ-025 SAT -> IDLE registers Out, Sat and Out_Valid=1.
REQ-026 Latency: Out_Valid rises 6 clocks after the edge that samples Sample.
REQ-027 Back-to-back operation: a new Sample is accepted in the first IDLE cycle after Out_Valid.
REQ-028 Enable=0 in any state forces IDLE next clock and sets Out=0, Sat=0, IE=0, PE_prev=PE, with no Out_Valid.
REQ-029 Enable=0 and Sample=1 in the same cycle: Enable wins.
REQ-030 IE exactly at ±ILIM is legal and holds there; ILIM=0 forces IE=0.

Reset
REQ-031 Reset_n=0 at a clock edge sets FSM=IDLE, Out=0, Out_Valid=0, Busy=0, Sat=0, PE=0, IE=0 and PE_prev=0.
REQ-032 Reset during a computation abandons it with no Out_Valid; the Reset_n=0 clock ignores Sample.

Configuration
REQ-033 Macro PID_DERIV_EN.
REQ-034 With PID_DERIV_EN defined: the MUL_D state exists, DT contributes to the sum, and latency is 6.
REQ-035 Without PID_DERIV_EN: no MUL_D state, no DE/PE_prev storage, DT=0, and latency is 5; DC is ignored.

Verification
REQ-036 Reset then Pos=0x090BE, Enc=0x090AE, PC=0x200, IC=DC=0, Sample -> PE=16, Out=32, Sat=0, Out_Valid 6 clocks later.
REQ-037 PC=0, IC=0x100, ILIM=40, PE=16, three Samples -> IE=16, 32, 40; Out=16, 32, 40.
REQ-038 Pos=0x3FFFF, Enc=0, PC=0xFFF -> Out=0x7FFF, Sat=1; swap Pos/Enc -> Out=0x8000, Sat=1.
REQ-039 DC=0x100, PE stepping 0 then 10, PC=IC=0 -> Out=10, then 0 at the next Sample with PE held at 10; without the macro -> Out=0 always, latency 5.
REQ-040 Sample repeated on the 3rd clock of Busy -> ignored, a single Out_Valid; Reset_n=0 on the 4th clock -> no Out_Valid, all outputs zero.
REQ-041 Enable dropped mid-computation -> Busy=0 next clock, Out=0, IE=0; re-enable and Sample -> normal result.
